// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, stall and flush controller for a five-stage in-order pipeline.
// Latency: hold/flush/stall outputs respond combinationally in the cycle the event is seen; state advances on clk.
// Backpressure: cache misses freeze the front end (and EX/MEM for D-side); load-use inserts one bubble.
// Optional build macro PIPE_CTRL_PERF_EN adds the stall-cycle and flush-count performance counters.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_valid,
  input  logic        id_rs2_valid,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_valid,
  input  logic        ex_is_load,
  input  logic        ex_valid,
  input  logic        branch_taken,
  input  logic        icache_stall_req,
  input  logic        dcache_stall_req,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_ex_hazard_stall,
  output logic        id_ex_cache_stall,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic [1:0]  state_out,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
);

  // FSM encoding is fixed because state_out is observed by software/debug.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_IC_WAIT  = 2'd2;
  localparam logic [1:0] ST_DC_WAIT  = 2'd3;

  // Per-cycle winning action; the output decode keys off this alone.
  localparam logic [2:0] ACT_NONE     = 3'd0;
  localparam logic [2:0] ACT_DC_HOLD  = 3'd1;
  localparam logic [2:0] ACT_IC_HOLD  = 3'd2;
  localparam logic [2:0] ACT_FLUSH    = 3'd3;
  localparam logic [2:0] ACT_LU_STALL = 3'd4;

  localparam logic [7:0] WAIT_MAX = 8'd255;

  logic [1:0] r_state;
  logic       r_flush_pend;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  logic       w_rs1_hit;
  logic       w_rs2_hit;
  logic       w_load_use;
  logic       w_in_wait;
  logic [2:0] w_act;
  logic [1:0] w_state_nxt;
  logic       w_pend_nxt;
  logic [7:0] w_cnt_nxt;

  // A load in EX whose destination a valid ID source reads cannot forward in time.
  assign w_rs1_hit  = id_rs1_valid & (id_rs1_addr == ex_rd_addr);
  assign w_rs2_hit  = id_rs2_valid & (id_rs2_addr == ex_rd_addr);
  assign w_load_use = ex_valid & ex_is_load & ex_rd_valid & (ex_rd_addr != 5'd0)
                    & (w_rs1_hit | w_rs2_hit);

  assign w_in_wait  = (r_state == ST_IC_WAIT) || (r_state == ST_DC_WAIT);

  // Pick the single winning event this cycle and the state it leads to.
  // While waiting, a held request keeps the freeze asserted; the cycle the request
  // drops the pipe is released and the FSM steps out on the next edge. A branch
  // resolved while frozen is remembered and its flush is issued on the first RUN cycle.
  always_comb begin
    w_act       = ACT_NONE;
    w_state_nxt = ST_RUN;
    w_pend_nxt  = r_flush_pend;
    if (w_in_wait) begin
      if (branch_taken) begin
        w_pend_nxt = 1'b1;
      end
      if (dcache_stall_req) begin
        w_act       = ACT_DC_HOLD;
        w_state_nxt = ST_DC_WAIT;
      end else if (icache_stall_req) begin
        w_act       = ACT_IC_HOLD;
        w_state_nxt = ST_IC_WAIT;
      end else begin
        w_act       = ACT_NONE;
        w_state_nxt = ST_RUN;
      end
    end else begin
      // RUN and LU_STALL share the same event rules; LU_STALL is just the bubble cycle.
      if (dcache_stall_req) begin
        w_act       = ACT_DC_HOLD;
        w_state_nxt = ST_DC_WAIT;
        if (branch_taken) begin
          w_pend_nxt = 1'b1;
        end
      end else if (branch_taken || r_flush_pend) begin
        w_act       = ACT_FLUSH;
        w_state_nxt = ST_RUN;
        w_pend_nxt  = 1'b0;
      end else if (icache_stall_req) begin
        w_act       = ACT_IC_HOLD;
        w_state_nxt = ST_IC_WAIT;
      end else if (w_load_use) begin
        w_act       = ACT_LU_STALL;
        w_state_nxt = ST_LU_STALL;
      end else begin
        w_act       = ACT_NONE;
        w_state_nxt = ST_RUN;
      end
    end
  end

  // Decode the winning action into the pipeline register controls; reset silences everything.
  always_comb begin
    pc_hold            = 1'b0;
    if_id_hold         = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    id_ex_hazard_stall = 1'b0;
    id_ex_cache_stall  = 1'b0;
    id_ex_hold         = 1'b0;
    ex_mem_hold        = 1'b0;
    if (!rst) begin
      case (w_act)
        ACT_DC_HOLD: begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_hold  = 1'b1;
          ex_mem_hold = 1'b1;
        end
        ACT_IC_HOLD: begin
          pc_hold           = 1'b1;
          if_id_hold        = 1'b1;
          id_ex_cache_stall = 1'b1;
        end
        ACT_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        ACT_LU_STALL: begin
          pc_hold            = 1'b1;
          if_id_hold         = 1'b1;
          id_ex_hazard_stall = 1'b1;
        end
        default: begin
          pc_hold = 1'b0;
        end
      endcase
    end
  end

  // Advance the FSM and the deferred-flush flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  // Consecutive cycles spent in a wait state, saturating so the count never wraps.
  assign w_cnt_nxt = !w_in_wait            ? 8'd0 :
                     (r_wait_cnt == WAIT_MAX) ? WAIT_MAX :
                     r_wait_cnt + 8'd1;

  // Track wait length and latch the watchdog flag once the saturation point is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_cnt_nxt;
      r_timeout  <= r_timeout | (w_cnt_nxt == WAIT_MAX);
    end
  end

  assign state_out     = r_state;
  assign stall_timeout = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Free-running event counters; natural 32-bit wrap is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (pc_hold) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (if_id_flush) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: event-priority reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_valid, id_rs2_valid, ex_rd_valid, ex_is_load, ex_valid;
  logic        branch_taken, icache_stall_req, dcache_stall_req;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush;
  logic        id_ex_hazard_stall, id_ex_cache_stall, id_ex_hold, ex_mem_hold;
  logic [1:0]  state_out;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles, perf_flush_count;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_valid(id_rs1_valid), .id_rs2_valid(id_rs2_valid),
    .ex_rd_addr(ex_rd_addr), .ex_rd_valid(ex_rd_valid),
    .ex_is_load(ex_is_load), .ex_valid(ex_valid),
    .branch_taken(branch_taken), .icache_stall_req(icache_stall_req),
    .dcache_stall_req(dcache_stall_req),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .id_ex_hazard_stall(id_ex_hazard_stall),
    .id_ex_cache_stall(id_ex_cache_stall), .id_ex_hold(id_ex_hold),
    .ex_mem_hold(ex_mem_hold), .state_out(state_out),
    .stall_timeout(stall_timeout), .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  // Reference model: mode 0 RUN, 1 bubble, 2 I-wait, 3 D-wait.
  int          m_st;
  logic        m_pend;
  int          m_wait;
  logic        m_to;
  logic [31:0] m_pstall, m_pflush;

  // Output vector order: pc, if_id_hold, if_id_flush, id_ex_flush, hazard, cache, id_ex_hold, ex_mem_hold.
  logic [7:0] dut_outs;
  assign dut_outs = {pc_hold, if_id_hold, if_id_flush, id_ex_flush,
                     id_ex_hazard_stall, id_ex_cache_stall, id_ex_hold, ex_mem_hold};

  function automatic logic lu_hit();
    if (!(ex_valid && ex_is_load && ex_rd_valid) || ex_rd_addr == 5'd0) return 1'b0;
    if (id_rs1_valid && id_rs1_addr == ex_rd_addr) return 1'b1;
    if (id_rs2_valid && id_rs2_addr == ex_rd_addr) return 1'b1;
    return 1'b0;
  endfunction

  // Which event wins this cycle: 0 none, 1 D-miss, 2 I-miss, 3 flush, 4 load-use.
  function automatic int winner();
    if (m_st >= 2) begin
      if (dcache_stall_req) return 1;
      if (icache_stall_req) return 2;
      return 0;
    end
    if (dcache_stall_req) return 1;
    if (branch_taken || m_pend) return 3;
    if (icache_stall_req) return 2;
    if (lu_hit()) return 4;
    return 0;
  endfunction

  function automatic logic [7:0] exp_outs();
    if (rst) return 8'h00;
    case (winner())
      1: return 8'b1100_0011;
      2: return 8'b1100_0100;
      3: return 8'b0011_0000;
      4: return 8'b1100_1000;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int next_mode();
    case (winner())
      1: return 3;
      2: return 2;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic next_pend();
    if (m_st >= 2) return m_pend || branch_taken;
    if (winner() == 3) return 1'b0;
    if (winner() == 1) return m_pend || branch_taken;
    return m_pend;
  endfunction

  function automatic logic [31:0] stall_inc();
    return (exp_outs() >= 8'h80) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] flush_inc();
    return ((exp_outs() & 8'h20) != 8'h00) ? 32'd1 : 32'd0;
  endfunction

  // Advance the model on every clock edge; reset is asynchronous like the DUT's.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st     <= 0;
      m_pend   <= 1'b0;
      m_wait   <= 0;
      m_to     <= 1'b0;
      m_pstall <= 32'd0;
      m_pflush <= 32'd0;
    end else begin
      m_st   <= next_mode();
      m_pend <= next_pend();
      m_wait <= (m_st >= 2) ? ((m_wait >= 255) ? 255 : m_wait + 1) : 0;
      m_to   <= m_to || (m_st >= 2 && m_wait >= 254);
      if (PERF) begin
        m_pstall <= m_pstall + stall_inc();
        m_pflush <= m_pflush + flush_inc();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("outs", {24'd0, dut_outs}, {24'd0, exp_outs()});
      chk("state", {30'd0, state_out}, m_st);
      chk("timeout", {31'd0, stall_timeout}, {31'd0, m_to});
      chk("perf_stall", perf_stall_cycles, m_pstall);
      chk("perf_flush", perf_flush_count, m_pflush);
    end
  end

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_valid = 1'b0; id_rs2_valid = 1'b0;
    ex_rd_addr = 5'd0; ex_rd_valid = 1'b0; ex_is_load = 1'b0; ex_valid = 1'b0;
    branch_taken = 1'b0; icache_stall_req = 1'b0; dcache_stall_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_valid = 1'b1; ex_rd_addr = rd;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", {24'd0, dut_outs}, 32'd0);
    chk("rst_state", {30'd0, state_out}, 32'd0);
    chk("rst_perf", perf_stall_cycles | perf_flush_count, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    dcache_stall_req = 1'b1;   // must be ignored while reset is high
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hold_forced0", {31'd0, pc_hold}, 32'd0);
    chk("reset_timeout", {31'd0, stall_timeout}, 32'd0);
    tick();
    rst = 1'b0;
    idle();

    // Load x5 in EX, ID reads rs2=x5: one stall cycle, one bubble, back to RUN.
    load_in_ex(5'd5); id_rs2_addr = 5'd5; id_rs2_valid = 1'b1;
    id_rs1_addr = 5'd3; id_rs1_valid = 1'b1;
    @(negedge clk);
    chk("lu_stall_vec", {29'd0, pc_hold, if_id_hold, id_ex_hazard_stall}, 32'd7);
    chk("lu_state_run", {30'd0, state_out}, 32'd0);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("lu_state_bubble", {30'd0, state_out}, 32'd1);
    chk("lu_bubble_quiet", {24'd0, dut_outs}, 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("lu_back_run", {30'd0, state_out}, 32'd0);
    tick();

    // Load to x0 read by ID: never a hazard.
    load_in_ex(5'd0); id_rs1_valid = 1'b1; id_rs2_valid = 1'b1;
    @(negedge clk);
    chk("x0_no_stall", {31'd0, pc_hold}, 32'd0);
    tick();
    // Matching rs1 that is not actually read: no hazard.
    load_in_ex(5'd7); id_rs1_addr = 5'd7; id_rs1_valid = 1'b0;
    id_rs2_addr = 5'd8; id_rs2_valid = 1'b1;
    @(negedge clk);
    chk("rs1_invalid_no_stall", {31'd0, id_ex_hazard_stall}, 32'd0);
    tick();
    id_rs1_valid = 1'b1;
    @(negedge clk);
    chk("rs1_hit_stall", {31'd0, id_ex_hazard_stall}, 32'd1);
    tick();
    idle();
    tick();

    // D-miss for 3 cycles with a branch in cycle 2: 3 hold cycles, one flush afterwards.
    dcache_stall_req = 1'b1;
    @(negedge clk);
    chk("dc_c1_hold", {24'd0, dut_outs}, 32'h000000c3);
    tick();
    branch_taken = 1'b1;
    @(negedge clk);
    chk("dc_c2_noflush", {31'd0, if_id_flush}, 32'd0);
    chk("dc_c2_state", {30'd0, state_out}, 32'd3);
    tick();
    branch_taken = 1'b0;
    tick();
    dcache_stall_req = 1'b0;
    @(negedge clk);
    chk("dc_release", {31'd0, pc_hold | if_id_flush}, 32'd0);
    tick();
    @(negedge clk);
    chk("dc_late_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    chk("dc_late_state", {30'd0, state_out}, 32'd0);
    tick();
    @(negedge clk);
    chk("dc_flush_once", {31'd0, if_id_flush}, 32'd0);
    tick();

    // Priority: branch beats icache and load-use; icache beats load-use.
    branch_taken = 1'b1; icache_stall_req = 1'b1;
    load_in_ex(5'd9); id_rs1_addr = 5'd9; id_rs1_valid = 1'b1;
    @(negedge clk);
    chk("prio_branch", {24'd0, dut_outs}, 32'h00000030);
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("prio_icache", {24'd0, dut_outs}, 32'h000000c4);
    tick();
    idle();
    tick();
    tick();

    // Branch during the load-use bubble still flushes.
    load_in_ex(5'd4); id_rs2_addr = 5'd4; id_rs2_valid = 1'b1;
    tick();
    idle(); branch_taken = 1'b1;
    @(negedge clk);
    chk("lu_branch_flush", {31'd0, id_ex_flush}, 32'd1);
    tick();
    idle();
    tick();

    // D and I both missing, D resolves first: DC_WAIT, then IC_WAIT, then RUN.
    dcache_stall_req = 1'b1; icache_stall_req = 1'b1;
    tick();
    @(negedge clk);
    chk("both_dc_state", {30'd0, state_out}, 32'd3);
    tick();
    dcache_stall_req = 1'b0;
    @(negedge clk);
    chk("both_to_ic_outs", {24'd0, dut_outs}, 32'h000000c4);
    tick();
    @(negedge clk);
    chk("both_ic_state", {30'd0, state_out}, 32'd2);
    tick();
    icache_stall_req = 1'b0;
    tick();
    @(negedge clk);
    chk("both_run", {30'd0, state_out}, 32'd0);
    tick();

    // Reset while a flush is pending discards it.
    dcache_stall_req = 1'b1; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    reset_pulse();
    idle();
    @(negedge clk);
    chk("rst_drops_pending", {31'd0, if_id_flush}, 32'd0);
    tick();

    // I-miss held for 300 cycles: watchdog sets at count 255 and is sticky.
    icache_stall_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 255) chk("wd_before", {31'd0, stall_timeout}, 32'd0);
      if (i == 256) chk("wd_set", {31'd0, stall_timeout}, 32'd1);
      tick();
    end
    icache_stall_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
    reset_pulse();
    @(negedge clk);
    chk("wd_cleared", {31'd0, stall_timeout}, 32'd0);

    // Performance counters: 4 load-use stalls and 2 branches.
    for (int k = 0; k < 4; k++) begin
      load_in_ex(5'd12); id_rs1_addr = 5'd12; id_rs1_valid = 1'b1;
      tick();
      idle();
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0;
      tick();
    end
    @(negedge clk);
    chk("perf_stall_4", perf_stall_cycles, PERF ? 32'd4 : 32'd0);
    chk("perf_flush_2", perf_flush_count, PERF ? 32'd2 : 32'd0);
    tick();
    reset_pulse();
    @(negedge clk);
    chk("perf_cleared", perf_stall_cycles | perf_flush_count, 32'd0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
